// File: rtl/uart_prog_pkg.sv
// Shared types for the UART program loader: receiver/loader state encodings and error bit positions.
// No logic; imported by the receiver and the loader top.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_e;

  typedef enum logic [2:0] {
    L_LEN,
    L_DATA,
    L_WRITE,
    L_DONE,
    L_ERR
  } ld_state_e;

  localparam int ErrFrame   = 0;
  localparam int ErrOverrun = 1;
  localparam int ErrLen     = 2;

endpackage

// File: rtl/uart_prog_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte_vld_o pulse after a good stop bit.
// Latency ~2 cycles sync plus 9.5 bit times; no backpressure, the consumer must take each pulse.
module uart_prog_rx
  import uart_prog_pkg::*;
#(
  parameter int ClkPerBit = 16
) (
  input  logic       clock,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int CntW = $clog2(ClkPerBit) + 1;
  localparam logic [CntW-1:0] HalfBit = CntW'(ClkPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullBit = CntW'(ClkPerBit - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            vld_q, vld_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = R_START;
      end
      R_START: begin
        // A line that is high again at mid start bit was a glitch.
        if (cnt_q == HalfBit) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == FullBit) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == FullBit) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            vld_d   = 1'b1;
            state_d = R_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = R_BREAK;
          end
        end
      end
      R_BREAK: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
    end
  end

  assign byte_o      = shift_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: length-prefixed little-endian word image into imem, core held in reset until done.
// One-byte skid between receiver and loader; a stalled grant overruns it and latches an error.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int ClkPerBit = 16,
  parameter int AddrWidth = 12,
  parameter int MaxWords  = 1024
) (
  input  logic                 clock,
  input  logic                 reset_ni,
  input  logic                 uart_rx_i,
  input  logic                 prog_en_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_gnt_i,
  output logic                 core_rst_no,
  output logic                 done_o,
  output logic [2:0]           err_o,
  output logic [15:0]          word_cnt_o
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;

  uart_prog_rx #(.ClkPerBit(ClkPerBit)) u_rx (
    .clock      (clock),
    .reset_ni   (reset_ni),
    .rx_i       (uart_rx_i),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .frame_err_o(rx_ferr)
  );

  ld_state_e            state_q, state_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [7:0]           skid_dat_q, skid_dat_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [31:0]          len_q, len_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [15:0]          word_cnt_q, word_cnt_d;
  logic [2:0]           err_q, err_d;
  logic                 done_q, done_d;
  logic                 pop, accept, ovr;

  always_comb begin
    pop    = skid_vld_q && (state_q == L_LEN || state_q == L_DATA);
    accept = rx_vld && state_q != L_DONE && state_q != L_ERR;
    ovr    = accept && skid_vld_q && !pop;

    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;

    // Pop before store, so a byte arriving in the pop cycle is kept.
    if (pop) skid_vld_d = 1'b0;
    if (accept && !ovr) begin
      skid_vld_d = 1'b1;
      skid_dat_d = rx_byte;
    end

    case (state_q)
      L_LEN: begin
        if (byte_idx_q == 2'd0 && !prog_en_i) begin
          state_d = L_DONE;
        end else if (pop) begin
          len_d      = {skid_dat_q, len_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (len_d == 32'd0) begin
              state_d = L_DONE;
            end else if (len_d > 32'(MaxWords)) begin
              err_d[ErrLen] = 1'b1;
              state_d       = L_ERR;
            end else begin
              state_d = L_DATA;
            end
          end
        end
      end
      L_DATA: begin
        if (pop) begin
          wdata_d    = {skid_dat_q, wdata_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = L_WRITE;
        end
      end
      L_WRITE: begin
        if (mem_gnt_i) begin
          addr_d     = addr_q + AddrWidth'(4);
          word_cnt_d = word_cnt_q + 16'd1;
          state_d    = ({16'd0, word_cnt_d} == len_q) ? L_DONE : L_DATA;
        end
      end
      L_DONE:  state_d = L_DONE;
      L_ERR:   state_d = L_ERR;
      default: state_d = L_ERR;
    endcase

    if (state_q != L_DONE && (rx_ferr || ovr)) begin
      state_d = L_ERR;
      if (rx_ferr) err_d[ErrFrame] = 1'b1;
      if (ovr) err_d[ErrOverrun] = 1'b1;
    end

    done_d = (state_d == L_DONE);
  end

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= L_LEN;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      byte_idx_q <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign mem_req_o   = (state_q == L_WRITE);
  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign done_o      = done_q;
  assign core_rst_no = done_q;
  assign err_o       = err_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial stimulus tasks, grant responder and write scoreboard.
module tb_uart_prog_loader;

  localparam int CPB  = 16;
  localparam int AW   = 12;
  localparam int MAXW = 1024;

  logic          clock = 1'b0;
  logic          reset_ni = 1'b0;
  logic          uart_rx_i = 1'b1;
  logic          prog_en_i = 1'b1;
  logic          mem_gnt_i = 1'b0;
  logic          mem_req_o, mem_we_o, core_rst_no, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [2:0]    err_o;
  logic [15:0]   word_cnt_o;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           got;
  int            n_checks = 0;
  int            n_fail = 0;
  int            wr_count = 0, req_cycles = 0, req_idx = 0, wait_cnt = 0;
  int            cyc = 0, last_grant_cyc = -100, done_rise_cyc = -1;
  bit            done_seen = 0, pending = 0, tie_gnt = 0;
  int            first_delay = 0, later_delay = 0;
  logic [AW-1:0] held_addr;
  logic [31:0]   held_data;

  uart_prog_loader #(.ClkPerBit(CPB), .AddrWidth(AW), .MaxWords(MAXW)) dut (
    .clock      (clock),
    .reset_ni   (reset_ni),
    .uart_rx_i  (uart_rx_i),
    .prog_en_i  (prog_en_i),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i  (mem_gnt_i),
    .core_rst_no(core_rst_no),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  always #5 clock = ~clock;

  // Grant responder and write monitor, acting on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (!reset_ni) begin
      wr_count = 0; req_cycles = 0; req_idx = 0; wait_cnt = 0; pending = 0;
      done_seen = 0; done_rise_cyc = -1; last_grant_cyc = -100; mem_gnt_i = 1'b0;
    end else begin
      if (done_o && !done_seen) begin done_seen = 1; done_rise_cyc = cyc; end
      if (mem_req_o) begin
        req_cycles++;
        n_checks++;
        if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL we_eq_req: we=%b req=1", mem_we_o); end
        if (pending) begin
          n_checks++;
          if (mem_addr_o !== held_addr || mem_wdata_o !== held_data) begin
            n_fail++;
            $display("FAIL req_stable: got %h/%h required %h/%h", mem_addr_o, mem_wdata_o, held_addr, held_data);
          end
        end else begin
          held_addr = mem_addr_o; held_data = mem_wdata_o; wait_cnt = 0;
        end
        mem_gnt_i = tie_gnt || (wait_cnt >= ((req_idx == 0) ? first_delay : later_delay));
        wait_cnt++;
        if (mem_gnt_i) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr=%h data=%h required none", mem_addr_o, mem_wdata_o);
          end else begin
            got = exp_q.pop_front();
            if (mem_addr_o !== got.addr || mem_wdata_o !== got.data) begin
              n_fail++;
              $display("FAIL write: got %h/%h required %h/%h", mem_addr_o, mem_wdata_o, got.addr, got.data);
            end
          end
          wr_count++; req_idx++; pending = 0; last_grant_cyc = cyc;
        end else begin
          pending = 1;
        end
      end else begin
        pending = 0;
        mem_gnt_i = tie_gnt;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin uart_rx_i = b[i]; tick(CPB); end
    uart_rx_i = stop; tick(CPB);
    if (!stop) begin uart_rx_i = 1'b1; tick(CPB); end
  endtask

  task automatic send_len(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic start(input logic pe, input bit tie, input int d0, input int d1);
    reset_ni = 1'b0; uart_rx_i = 1'b1; prog_en_i = pe;
    tie_gnt = tie; first_delay = d0; later_delay = d1;
    exp_q.delete();
    tick(3);
    reset_ni = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_o; i++) tick(1);
  endtask

  task automatic test_reset;
    reset_ni = 1'b0; tick(3);
    n_checks++;
    if ({mem_req_o, mem_we_o, core_rst_no, done_o, err_o} !== 7'b0 ||
        mem_addr_o !== '0 || mem_wdata_o !== '0 || word_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b we=%b rst_n=%b done=%b err=%b addr=%h wdata=%h cnt=%0d required all 0",
               mem_req_o, mem_we_o, core_rst_no, done_o, err_o, mem_addr_o, mem_wdata_o, word_cnt_o);
    end
  endtask

  task automatic test_bypass;
    start(1'b0, 1'b1, 0, 0);
    tick(2);
    n_checks++;
    if (done_o !== 1'b1 || core_rst_no !== 1'b1) begin
      n_fail++; $display("FAIL bypass_done: done=%b rst_n=%b required 1/1", done_o, core_rst_no);
    end
    send_byte(8'h55, 1'b1);
    tick(20);
    n_checks++;
    if (req_cycles !== 0 || err_o !== 3'b000) begin
      n_fail++; $display("FAIL bypass_quiet: req_cycles=%0d err=%b required 0/000", req_cycles, err_o);
    end
  endtask

  task automatic test_image;
    start(1'b1, 1'b1, 0, 0);
    exp_q.push_back('{addr: 12'h000, data: 32'h12345678});
    exp_q.push_back('{addr: 12'h004, data: 32'hDEADBEEF});
    send_len(32'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    wait_done(200);
    tick(2);
    n_checks++;
    if (wr_count !== 2 || word_cnt_o !== 16'd2 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL image_writes: writes=%0d word_cnt=%0d left=%0d required 2/2/0", wr_count, word_cnt_o, exp_q.size());
    end
    n_checks++;
    if (done_o !== 1'b1 || core_rst_no !== 1'b1 || err_o !== 3'b000) begin
      n_fail++; $display("FAIL image_done: done=%b rst_n=%b err=%b required 1/1/000", done_o, core_rst_no, err_o);
    end
    n_checks++;
    if (done_rise_cyc != last_grant_cyc + 1) begin
      n_fail++; $display("FAIL done_timing: rise at %0d required %0d", done_rise_cyc, last_grant_cyc + 1);
    end
  endtask

  task automatic test_back_to_back;
    start(1'b1, 1'b0, 5, 25 * CPB);
    exp_q.push_back('{addr: 12'h000, data: 32'h12345678});
    send_len(32'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    n_checks++;
    if (err_o !== 3'b000 || mem_req_o !== 1'b1 || wr_count !== 1) begin
      n_fail++; $display("FAIL slow_first: err=%b req=%b writes=%0d required 000/1/1", err_o, mem_req_o, wr_count);
    end
    send_byte(8'h11, 1'b1);
    n_checks++;
    if (err_o !== 3'b000 || mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL skid_hold: err=%b req=%b required 000/1", err_o, mem_req_o);
    end
    send_byte(8'h22, 1'b1);
    tick(5);
    n_checks++;
    if (err_o !== 3'b010 || core_rst_no !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL overrun: err=%b rst_n=%b done=%b req=%b required 010/0/0/0", err_o, core_rst_no, done_o, mem_req_o);
    end
    n_checks++;
    if (wr_count !== 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL overrun_writes: writes=%0d left=%0d required 1/0", wr_count, exp_q.size());
    end
  endtask

  task automatic test_frame_err;
    start(1'b1, 1'b1, 0, 0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    tick(5);
    n_checks++;
    if (err_o !== 3'b001 || done_o !== 1'b0 || core_rst_no !== 1'b0) begin
      n_fail++; $display("FAIL frame_err: err=%b done=%b rst_n=%b required 001/0/0", err_o, done_o, core_rst_no);
    end
    send_byte(8'h00, 1'b1);
    send_word(32'hCAFEF00D);
    tick(5);
    n_checks++;
    if (req_cycles !== 0 || err_o !== 3'b001 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL frame_stuck: req_cycles=%0d err=%b done=%b required 0/001/0", req_cycles, err_o, done_o);
    end
  endtask

  task automatic test_glitch_len0;
    start(1'b1, 1'b1, 0, 0);
    tick(4);
    uart_rx_i = 1'b0; tick(CPB / 4);
    uart_rx_i = 1'b1; tick(3 * CPB);
    n_checks++;
    if (err_o !== 3'b000 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL glitch: err=%b done=%b required 000/0", err_o, done_o);
    end
    send_len(32'd0);
    tick(5);
    n_checks++;
    if (done_o !== 1'b1 || core_rst_no !== 1'b1 || err_o !== 3'b000 || req_cycles !== 0) begin
      n_fail++; $display("FAIL len_zero: done=%b rst_n=%b err=%b req_cycles=%0d required 1/1/000/0", done_o, core_rst_no, err_o, req_cycles);
    end
  endtask

  task automatic test_len_err;
    start(1'b1, 1'b1, 0, 0);
    send_len(MAXW + 1);
    tick(5);
    n_checks++;
    if (err_o !== 3'b100 || core_rst_no !== 1'b0 || done_o !== 1'b0 || req_cycles !== 0) begin
      n_fail++; $display("FAIL len_err: err=%b rst_n=%b done=%b req_cycles=%0d required 100/0/0/0", err_o, core_rst_no, done_o, req_cycles);
    end
    uart_rx_i = 1'b0; tick(3 * CPB);
    #2 reset_ni = 1'b0;
    #1;
    n_checks++;
    if (err_o !== 3'b000 || done_o !== 1'b0 || core_rst_no !== 1'b0 || word_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL async_reset: err=%b done=%b rst_n=%b cnt=%0d required 000/0/0/0", err_o, done_o, core_rst_no, word_cnt_o);
    end
    uart_rx_i = 1'b1;
  endtask

  task automatic test_reset_mid_req;
    start(1'b1, 1'b0, 1000000, 1000000);
    send_len(32'd1);
    send_word(32'hA5A5_0F0F);
    tick(4);
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 12'h000 || mem_wdata_o !== 32'hA5A5_0F0F) begin
      n_fail++; $display("FAIL pending_req: req=%b addr=%h data=%h required 1/000/a5a50f0f", mem_req_o, mem_addr_o, mem_wdata_o);
    end
    #2 reset_ni = 1'b0;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_wdata_o !== 32'd0) begin
      n_fail++; $display("FAIL req_drop: req=%b we=%b data=%h required 0/0/0", mem_req_o, mem_we_o, mem_wdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_image();
    test_back_to_back();
    test_frame_err();
    test_glitch_len0();
    test_len_err();
    test_reset_mid_req();
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
